// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial adder
package serial_adder_pkg;
  localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one-bit full adder made from two half-adder cells plus a carry OR
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;
  assign s0 = a ^ b;
  assign c0 = a & b;
  assign s  = s0 ^ ci;
  assign c1 = s0 & ci;
  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock; SERIAL_ADDER_OVF_EN adds a two's-complement ovf output
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb, ss;
  logic carry, s, co;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
`endif
  full_adder_bit u_fa (.a(sa[0]), .b(sb[0]), .ci(carry), .s(s), .co(co));
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // next state: accept in IDLE, count bits in ADD, single-cycle DONE
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (start ? ADD : IDLE) :
          state == ADD  ? (cnt == LAST ? DONE : ADD) : IDLE;
  end
  // operand capture, serial datapath and result holding
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      ss <= '0;
      carry <= 1'b0;
      cnt <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= b;
      ss <= '0;
      carry <= cin;
      cnt <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (state == ADD) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      ss <= (ss >> 1) | (WIDTH'(s) << (WIDTH - 1));
      carry <= co;
      cnt <= cnt + CW'(1);
`ifdef SERIAL_ADDER_OVF_EN
      if (cnt == LAST) ovf_q <= carry ^ co;
`endif
    end
  end
  assign ready = state == IDLE;
  assign busy  = state == ADD;
  assign done  = state == DONE;
  assign sum   = ss;
  assign cout  = carry;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against a plain-arithmetic model
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic ready, busy, done, cout;
  logic [W-1:0] sum;
  int tests = 0, fails = 0;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input string tag);
    logic [W:0] e;
    e = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      chk({tag, " busy"}, {31'b0, busy & ~done & ~ready}, 32'd1);
      step();
    end
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " sum"}, 32'(sum), 32'(e[W-1:0]));
    chk({tag, " cout"}, {31'b0, cout}, {31'b0, e[W]});
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, {31'b0, ovf}, {31'b0, (x[W-1] == y[W-1]) && (e[W-1] != x[W-1])});
`endif
    step();
    chk({tag, " ready"}, {31'b0, ready & ~done}, 32'd1);
    chk({tag, " hold"}, 32'(sum), 32'(e[W-1:0]));
  endtask
  initial begin
    int last, ndone, seen_done;
    logic [W-1:0] rx, ry;
    logic rc;
    step();
    step();
    rst = 1'b0;
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst cout", {31'b0, cout}, 32'd0);
    step();
    op(8'h00, 8'h00, 1'b0, "zero");
    op(8'hFF, 8'h01, 1'b0, "ff+1");
    op(8'h5A, 8'hA5, 1'b1, "5a+a5+1");
    op(8'h3C, 8'h0F, 1'b0, "3c+0f");
    op(8'h7F, 8'h01, 1'b0, "7f+1");
    op(8'h80, 8'h80, 1'b1, "80+80+1");
    for (int i = 0; i < 10; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom);
      op(rx, ry, rc, "rand");
    end
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    last = -1;
    ndone = 0;
    for (int t = 0; t < 5 * (W + 2); t++) begin
      step();
      if (busy) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'b1;
      end else begin
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
      end
      if (done) begin
        chk("held sum", 32'(sum), 32'h30);
        chk("held cout", {31'b0, cout}, 32'd0);
        if (last >= 0) chk("held period", t - last, W + 2);
        last = t;
        ndone++;
      end
    end
    chk("held count", ndone, 5);
    start = 1'b0;
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    for (int t = 0; t < W + 2; t++) step();
    chk("idle before abort", {31'b0, ready}, 32'd1);
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort ready", {31'b0, ready}, 32'd1);
    chk("abort sum", 32'(sum), 32'd0);
    chk("abort cout", {31'b0, cout}, 32'd0);
    seen_done = {31'b0, done};
    for (int t = 0; t < W + 2; t++) begin
      step();
      seen_done |= {31'b0, done};
    end
    chk("abort no done", seen_done, 0);
    op(8'h01, 8'h01, 1'b0, "after abort");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
